handshake_elastic_fifo: RTL and testbench

//  Opaque elastic FIFO buffer for handshake dataflow channels. Sits directly downstream of

---
 rtl/handshake_elastic_fifo_pkg.sv | 30 +++
 rtl/handshake_fifo_mem.sv | 32 +++
 rtl/handshake_elastic_fifo.sv | 90 +++++++++
 tb/tb_handshake_elastic_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/handshake_elastic_fifo_pkg.sv
// Shared helpers for the handshake_* dataflow blocks.
//   ptr_width(n)  : ceil(log2(n)) floored at 1, usable in parameter context.
//   HS_IN_CHANNEL / HS_OUT_CHANNEL : port-bundle macros for a handshake channel
//     given its data, valid and ready port names, data port <width> bits wide.
`ifndef HANDSHAKE_CHANNEL_MACROS
`define HANDSHAKE_CHANNEL_MACROS
`define HS_IN_CHANNEL(data, valid, ready, width) \
  input  logic [(width)-1:0] data, \
  input  logic               valid, \
  output logic               ready
`define HS_OUT_CHANNEL(data, valid, ready, width) \
  output logic [(width)-1:0] data, \
  output logic               valid, \
  input  logic               ready
`endif

package handshake_elastic_fifo_pkg;

  // Bits needed to address n distinct values; never less than 1 so a
  // degenerate depth still yields a legal vector.
  function automatic int unsigned ptr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/handshake_fifo_mem.sv
// Storage array for handshake_elastic_fifo. No reset, no pointer logic.
//   clk_i    : write clock
//   we_i     : write enable
//   waddr_i  : write slot index
//   wdata_i  : write data
//   raddr_i  : read slot index (combinational read)
//   rdata_o  : contents of slot raddr_i
module handshake_fifo_mem
  import handshake_elastic_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLOTS  = 4
) (
  input  logic                                clk_i,
  input  logic                                we_i,
  input  logic [ptr_width(NUM_SLOTS)-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0]               wdata_i,
  input  logic [ptr_width(NUM_SLOTS)-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0]               rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_SLOTS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/handshake_elastic_fifo.sv
// Opaque elastic FIFO for a handshake channel. Every output is derived from
// registered state, so valid, data and ready paths are all cut.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset (drops all buffered tokens)
//   ins        : input token data
//   ins_valid  : input token present
//   ins_ready  : a slot is free this cycle
//   outs       : token at head (don't-care while outs_valid = 0)
//   outs_valid : at least one token buffered
//   outs_ready : consumer takes the head token
module handshake_elastic_fifo
  import handshake_elastic_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int unsigned PtrW = ptr_width(NUM_SLOTS);
  localparam int unsigned CntW = ptr_width(NUM_SLOTS + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NUM_SLOTS - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(NUM_SLOTS);

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;

  // Wrap explicitly so non-power-of-two depths never rely on overflow.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // When full, ready stays low even if a pop happens this cycle; the freed
  // slot shows up next cycle, keeping outs_ready off the ins_ready path.
  assign ins_ready  = (count_q != FullCnt);
  assign outs_valid = (count_q != '0);
  assign push       = ins_valid & ins_ready;
  assign pop        = outs_valid & outs_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      tail_d = next_ptr(tail_q);
    end
    if (pop) begin
      head_d = next_ptr(head_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  handshake_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SLOTS  (NUM_SLOTS)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push & ~rst),
    .waddr_i (tail_q),
    .wdata_i (ins),
    .raddr_i (head_q),
    .rdata_o (outs)
  );

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Bench for handshake_elastic_fifo: channel A (4 slots) gets directed
// scenarios, channel B (3 slots) gets random valid/ready traffic. Each channel
// has a queue-based reference model checked on the falling edge.
module tb_handshake_elastic_fifo;

  localparam int unsigned W       = 32;
  localparam int          ASlots  = 4;
  localparam int          BSlots  = 3;
  localparam int          BTokens = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         a_rst, a_ins_valid, a_ins_ready, a_outs_valid, a_outs_ready;
  logic [W-1:0] a_ins, a_outs;
  logic         b_rst, b_ins_valid, b_ins_ready, b_outs_valid, b_outs_ready;
  logic [W-1:0] b_ins, b_outs;

  handshake_elastic_fifo #(.DATA_WIDTH(W), .NUM_SLOTS(ASlots)) dut_a (
    .clk        (clk),
    .rst        (a_rst),
    .ins        (a_ins),
    .ins_valid  (a_ins_valid),
    .ins_ready  (a_ins_ready),
    .outs       (a_outs),
    .outs_valid (a_outs_valid),
    .outs_ready (a_outs_ready)
  );

  handshake_elastic_fifo #(.DATA_WIDTH(W), .NUM_SLOTS(BSlots)) dut_b (
    .clk        (clk),
    .rst        (b_rst),
    .ins        (b_ins),
    .ins_valid  (b_ins_valid),
    .ins_ready  (b_ins_ready),
    .outs       (b_outs),
    .outs_valid (b_outs_valid),
    .outs_ready (b_outs_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  logic [W-1:0] a_exp[$];
  logic [W-1:0] b_exp[$];
  int a_recv = 0;
  int b_recv = 0;

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model A: occupancy is the queue size; a token is accepted when
  // the queue had room at the start of the cycle, and only leaves on a pop.
  always @(negedge clk) begin
    int occ;
    if (chk_en) begin
      occ = a_exp.size();
      check_bit("a_ins_ready", a_ins_ready, occ != ASlots);
      check_bit("a_outs_valid", a_outs_valid, occ != 0);
      if (occ != 0 && a_outs_valid) check_word("a_outs", a_outs, a_exp[0]);
      if (a_rst) begin
        a_exp.delete();
      end else begin
        if (occ != 0 && a_outs_ready) begin
          void'(a_exp.pop_front());
          a_recv++;
        end
        if (a_ins_valid && occ < ASlots) a_exp.push_back(a_ins);
      end
    end
  end

  always @(negedge clk) begin
    int occ;
    if (chk_en) begin
      occ = b_exp.size();
      check_bit("b_ins_ready", b_ins_ready, occ != BSlots);
      check_bit("b_outs_valid", b_outs_valid, occ != 0);
      if (occ != 0 && b_outs_valid) check_word("b_outs", b_outs, b_exp[0]);
      if (b_rst) begin
        b_exp.delete();
      end else begin
        if (occ != 0 && b_outs_ready) begin
          void'(b_exp.pop_front());
          b_recv++;
        end
        if (b_ins_valid && occ < BSlots) b_exp.push_back(b_ins);
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_a();
    // Reset held with a valid token offered: nothing may get buffered.
    a_rst = 1'b1; a_ins_valid = 1'b1; a_ins = 32'h77; a_outs_ready = 1'b1;
    step(3);
    a_rst = 1'b0; a_ins_valid = 1'b0;
    step(2);
    // Single token with consumer always ready.
    a_ins = 32'h09; a_ins_valid = 1'b1;
    step(1);
    a_ins_valid = 1'b0;
    step(3);
    // Fill to full, stall a fifth, then drain.
    a_outs_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      a_ins = W'(i); a_ins_valid = 1'b1;
      step(1);
    end
    a_ins = 32'd5;
    step(3);
    a_outs_ready = 1'b1;
    step(2);
    a_ins_valid = 1'b0;
    step(6);
    // Streaming 0..99.
    for (int i = 0; i < 100; i++) begin
      a_ins = W'(i); a_ins_valid = 1'b1;
      step(1);
    end
    a_ins_valid = 1'b0;
    step(3);
    // Reset with three tokens buffered.
    a_outs_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_ins = W'(32'h11 * (i + 1)); a_ins_valid = 1'b1;
      step(1);
    end
    a_ins_valid = 1'b0;
    a_rst = 1'b1;
    step(1);
    a_rst = 1'b0;
    step(1);
    a_ins = 32'hAA; a_ins_valid = 1'b1;
    step(1);
    a_ins_valid = 1'b0; a_outs_ready = 1'b1;
    step(4);
    // 0x09, 1..5, 0..99, 0xAA
    check_int("a_token_count", a_recv, 107);
  endtask

  task automatic run_b();
    int sent;
    int cycles;
    logic fire;
    sent = 0; cycles = 0;
    b_rst = 1'b1; b_ins_valid = 1'b0; b_outs_ready = 1'b0; b_ins = '0;
    step(3);
    b_rst = 1'b0;
    b_ins = $urandom;
    while (sent < BTokens && cycles < 20000) begin
      b_ins_valid  = 1'($urandom_range(0, 1));
      b_outs_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      fire = b_ins_valid && b_ins_ready;
      @(posedge clk);
      #1;
      cycles++;
      if (fire) begin
        sent++;
        b_ins = $urandom;
      end
    end
    check_int("b_tokens_sent", sent, BTokens);
    b_ins_valid = 1'b0; b_outs_ready = 1'b1;
    step(6);
    check_int("b_tokens_received", b_recv, BTokens);
  endtask

  initial begin
    a_rst = 1'b1; a_ins_valid = 1'b0; a_outs_ready = 1'b0; a_ins = '0;
    b_rst = 1'b1; b_ins_valid = 1'b0; b_outs_ready = 1'b0; b_ins = '0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    fork
      run_a();
      run_b();
    join
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
